instruction_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the processor controller. Owns the program counter and reads 16-bit instruction words from instruction memory over a ready handshake.
- Presents each instruction to the controller for one execute cycle. Then samples the controller's registered PC-control outputs and ZeroFlag to pick the next PC: sequential, jump or zero-branch.
- Non-pipelined: one instruction in flight.

---
 rtl/instruction_fetch_unit_pkg.sv | 21 ++
 rtl/instruction_fetch_unit_next_pc_logic.sv | 41 ++++
 rtl/instruction_fetch_unit.sv | 139 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: opcode values, fetch FSM
// state encoding and the default PC width.
package instruction_fetch_unit_pkg;

  localparam int unsigned PC_WIDTH_DEFAULT = 32'd12;

  localparam logic [3:0] OP_LOAD  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_JUMP  = 4'b0010;
  localparam logic [3:0] OP_BRZ   = 4'b0100;
  localparam logic [3:0] OP_ALU   = 4'b1000;
  localparam logic [3:0] OP_ADDI  = 4'b1100;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_EXEC = 2'd2,
    S_UPD  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_next_pc_logic.sv
// Combinational next-PC selection: jump target, zero-branch with sign-extended
// 8-bit offset, or sequential PC+1. All arithmetic wraps modulo 2^PC_WIDTH.
module instruction_fetch_unit_next_pc_logic
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned PC_WIDTH = PC_WIDTH_DEFAULT
) (
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [15:0]         instruction,
  input  logic                load_pc_enable,
  input  logic                select_jump_pc,
  input  logic                select_branch_pc,
  input  logic                zero_flag,
  output logic [PC_WIDTH-1:0] next_pc
);

  logic [3:0]          opcode_s;
  logic [PC_WIDTH-1:0] seq_pc_s;
  logic [PC_WIDTH-1:0] branch_off_s;
  logic [PC_WIDTH-1:0] branch_pc_s;
  logic [PC_WIDTH-1:0] jump_pc_s;

  assign opcode_s     = instruction[15:12];
  assign seq_pc_s     = pc + PC_WIDTH'(1);
  assign branch_off_s = {{(PC_WIDTH - 8){instruction[7]}}, instruction[7:0]};
  assign branch_pc_s  = seq_pc_s + branch_off_s;
  assign jump_pc_s    = instruction[PC_WIDTH-1:0];

  // Select lines are only honoured for the matching opcode; stale selects fall through to PC+1.
  always_comb begin
    next_pc = seq_pc_s;
    if ((opcode_s == OP_JUMP) && load_pc_enable && select_jump_pc) begin
      next_pc = jump_pc_s;
    end else if ((opcode_s == OP_BRZ) && load_pc_enable && select_branch_pc && zero_flag) begin
      next_pc = branch_pc_s;
    end else begin
      next_pc = seq_pc_s;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Non-pipelined fetch stage: owns the PC, fetches one 16-bit instruction over a
// ready handshake with timeout/retry, presents it for one cycle, then updates PC.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned PC_WIDTH = PC_WIDTH_DEFAULT,
  parameter int unsigned RESET_PC = 32'd0,
  parameter int unsigned TIMEOUT  = 32'd15
) (
  input  logic                clk,
  input  logic                rst,
  output logic [PC_WIDTH-1:0] InstMemAddress,
  output logic                InstMemRead,
  input  logic                InstMemReady,
  input  logic [15:0]         InstMemData,
  output logic [15:0]         Instruction,
  output logic                InstructionValid,
  input  logic                LoadPcEnable,
  input  logic                SelectBranchPc,
  input  logic                SelectJumpPc,
  input  logic                ZeroFlag,
  input  logic                Stall,
  output logic [PC_WIDTH-1:0] Pc,
  output logic [15:0]         RetiredCount,
  output logic                FetchError
);

  localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT + 32'd1);

  fetch_state_e         state_q, state_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic [15:0]          instr_q, instr_d;
  logic                 instr_valid_q, instr_valid_d;
  logic                 mem_read_q, mem_read_d;
  logic [15:0]          retired_q, retired_d;
  logic                 fetch_error_q, fetch_error_d;
  logic [CNT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_WIDTH-1:0] wait_cnt_inc_s;
  logic [PC_WIDTH-1:0]  next_pc_s;

  assign wait_cnt_inc_s = wait_cnt_q + CNT_WIDTH'(1);

  instruction_fetch_unit_next_pc_logic #(
    .PC_WIDTH (PC_WIDTH)
  ) u_next_pc (
    .pc               (pc_q),
    .instruction      (instr_q),
    .load_pc_enable   (LoadPcEnable),
    .select_jump_pc   (SelectJumpPc),
    .select_branch_pc (SelectBranchPc),
    .zero_flag        (ZeroFlag),
    .next_pc          (next_pc_s)
  );

  // Fetch FSM next-state and registered-output computation.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    mem_read_d    = mem_read_q;
    retired_d     = retired_q;
    fetch_error_d = fetch_error_q;
    wait_cnt_d    = wait_cnt_q;
    case (state_q)
      S_REQ: begin
        mem_read_d = 1'b1;
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        // Ready wins even on the cycle the counter would expire.
        if (InstMemReady) begin
          instr_d       = InstMemData;
          mem_read_d    = 1'b0;
          instr_valid_d = 1'b1;
          state_d       = S_EXEC;
        end else if (wait_cnt_inc_s == CNT_WIDTH'(TIMEOUT)) begin
          wait_cnt_d    = wait_cnt_inc_s;
          fetch_error_d = 1'b1;
          mem_read_d    = 1'b0;
          state_d       = S_REQ;
        end else begin
          wait_cnt_d = wait_cnt_inc_s;
        end
      end
      S_EXEC: begin
        instr_valid_d = 1'b0;
        state_d       = S_UPD;
      end
      S_UPD: begin
        if (Stall) begin
          state_d = S_UPD;
        end else begin
          pc_d      = next_pc_s;
          retired_d = retired_q + 16'd1;
          state_d   = S_REQ;
        end
      end
      default: begin
        mem_read_d    = 1'b0;
        instr_valid_d = 1'b0;
        state_d       = S_REQ;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_REQ;
      pc_q          <= PC_WIDTH'(RESET_PC);
      instr_q       <= 16'h0000;
      instr_valid_q <= 1'b0;
      mem_read_q    <= 1'b0;
      retired_q     <= 16'h0000;
      fetch_error_q <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      mem_read_q    <= mem_read_d;
      retired_q     <= retired_d;
      fetch_error_q <= fetch_error_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  assign InstMemAddress   = pc_q;
  assign InstMemRead      = mem_read_q;
  assign Instruction      = instr_q;
  assign InstructionValid = instr_valid_q;
  assign Pc               = pc_q;
  assign RetiredCount     = retired_q;
  assign FetchError       = fetch_error_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: random memory latency and
// controller behaviour checked against a behavioural PC model.
module tb_instruction_fetch_unit;

  localparam int TMO    = 15;
  localparam int NEVER  = -1;
  localparam int N_DIR  = 11;
  localparam int N_RAND = 150;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] InstMemAddress;
  logic        InstMemRead;
  logic        InstMemReady = 1'b0;
  logic [15:0] InstMemData = 16'h0000;
  logic [15:0] Instruction;
  logic        InstructionValid;
  logic        LoadPcEnable = 1'b0;
  logic        SelectBranchPc = 1'b0;
  logic        SelectJumpPc = 1'b0;
  logic        ZeroFlag = 1'b0;
  logic        Stall = 1'b0;
  logic [11:0] Pc;
  logic [15:0] RetiredCount;
  logic        FetchError;

  instruction_fetch_unit #(
    .PC_WIDTH (12),
    .RESET_PC (0),
    .TIMEOUT  (TMO)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .InstMemAddress   (InstMemAddress),
    .InstMemRead      (InstMemRead),
    .InstMemReady     (InstMemReady),
    .InstMemData      (InstMemData),
    .Instruction      (Instruction),
    .InstructionValid (InstructionValid),
    .LoadPcEnable     (LoadPcEnable),
    .SelectBranchPc   (SelectBranchPc),
    .SelectJumpPc     (SelectJumpPc),
    .ZeroFlag         (ZeroFlag),
    .Stall            (Stall),
    .Pc               (Pc),
    .RetiredCount     (RetiredCount),
    .FetchError       (FetchError)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] pc;
    logic [15:0] instr;
    logic [15:0] retired;
    int          gap;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] mem [4096];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic        ferr_m = 1'b0;
  bit          dir_mode = 1'b0;
  bit          hold = 1'b0;
  bit          abort = 1'b0;

  // Directed program: sequential run, jump, branch taken/not-taken, stale selects, wrap.
  logic [11:0] dir_addr  [N_DIR] = '{12'h000, 12'h001, 12'h002, 12'h003, 12'hABC, 12'h010,
                                     12'h00F, 12'h010, 12'h011, 12'h012, 12'hFFF};
  logic [15:0] dir_instr [N_DIR] = '{16'h8001, 16'h8001, 16'h8001, 16'h2ABC, 16'h2010, 16'h40FE,
                                     16'h2010, 16'h40FE, 16'h0123, 16'h2FFF, 16'h8001};
  logic [3:0]  dir_ctl   [N_DIR] = '{4'b0000, 4'b0000, 4'b0000, 4'b1100, 4'b1100, 4'b1011,
                                     4'b1100, 4'b1010, 4'b1111, 4'b1100, 4'b0000};
  int          dir_stall [N_DIR] = '{0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] rand_instr();
    logic [3:0]  op;
    logic [11:0] low;
    low = 12'($urandom);
    case ($urandom_range(0, 6))
      0: op = 4'b0000;
      1: op = 4'b0001;
      2: op = 4'b0010;
      3: op = 4'b0100;
      4: op = 4'b1000;
      5: op = 4'b1100;
      default: op = 4'($urandom);
    endcase
    return {op, low};
  endfunction

  // Reference next-PC rule, plain integer arithmetic modulo 4096.
  function automatic logic [11:0] ref_next_pc(input logic [11:0] pc, input logic [15:0] ins,
                                               input logic lpe, input logic sj,
                                               input logic sb, input logic zf);
    int t;
    if (ins[15:12] == 4'b0010 && lpe && sj) return ins[11:0];
    if (ins[15:12] == 4'b0100 && lpe && sb && zf) begin
      t = int'(pc) + 1 + int'($signed(ins[7:0]));
      return 12'(t & 4095);
    end
    t = int'(pc) + 1;
    return 12'(t & 4095);
  endfunction

  function automatic int pick_wait();
    int r;
    if (hold) return NEVER;
    if (dir_mode) return 0;
    r = int'($urandom_range(0, 99));
    if (r < 60) return 0;
    if (r < 82) return int'($urandom_range(1, 3));
    if (r < 90) return TMO - 1;
    if (r < 95) return NEVER;
    return int'($urandom_range(4, 10));
  endfunction

  // Memory model: ready after a chosen number of wait cycles, junk ready when idle.
  initial begin : responder
    int          k;
    int          w;
    int          lowcnt;
    logic        drove_ready;
    logic        retry_pending;
    logic [11:0] req_addr;
    k = 0; w = 0; lowcnt = 0; drove_ready = 1'b0; retry_pending = 1'b0; req_addr = 12'h000;
    forever begin
      @(negedge clk);
      if (rst) begin
        k = 0; drove_ready = 1'b0; retry_pending = 1'b0; ferr_m = 1'b0; InstMemReady = 1'b0;
      end else if (InstMemRead) begin
        if (k == 0) begin
          if (retry_pending) begin
            chk("retry_address", InstMemAddress, req_addr);
            chk("retry_read_low_cycles", lowcnt, 1);
            retry_pending = 1'b0;
          end
          w = pick_wait();
          req_addr = InstMemAddress;
        end else begin
          chk("address_stable_in_wait", InstMemAddress, req_addr);
        end
        if (k == w) begin
          InstMemReady = 1'b1; InstMemData = mem[InstMemAddress]; drove_ready = 1'b1;
        end else begin
          InstMemReady = 1'b0; InstMemData = 16'($urandom); drove_ready = 1'b0;
        end
        k++;
      end else begin
        if (k > 0) begin
          lowcnt = 1;
          if (!drove_ready) begin
            chk("timeout_wait_cycles", k, TMO);
            chk("fetch_error_on_timeout", FetchError, 1'b1);
            ferr_m = 1'b1;
            retry_pending = 1'b1;
          end
        end else begin
          lowcnt++;
        end
        k = 0; drove_ready = 1'b0;
        InstMemReady = ($urandom_range(0, 3) == 0);
        InstMemData = 16'($urandom);
      end
    end
  end

  // Monitor: every presented instruction is popped from the scoreboard and compared.
  initial begin : monitor
    exp_t e;
    int   last_cyc;
    last_cyc = -1;
    forever begin
      @(negedge clk);
      if (!rst && InstructionValid) begin
        if (sb_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_valid: actual instruction 0x%0h at Pc 0x%0h, required no InstructionValid",
                   Instruction, Pc);
        end else begin
          e = sb_q.pop_front();
          chk("instruction", Instruction, e.instr);
          chk("pc_at_exec", Pc, e.pc);
          chk("inst_mem_address", InstMemAddress, e.pc);
          chk("retired_count", RetiredCount, e.retired);
          chk("fetch_error", FetchError, ferr_m);
          if (e.gap > 0) chk("valid_spacing", cyc - last_cyc, e.gap);
        end
        last_cyc = cyc;
      end
    end
  end

  // Driver: acts as the controller and advances the reference PC model.
  initial begin : driver
    logic [11:0] pc_m;
    logic [15:0] ret_m;
    logic [15:0] instr;
    logic        lpe, sj, sb, zf;
    int          stall;
    int          prev_stall;
    bit          ok;

    for (int a = 0; a < 4096; a++) mem[a] = rand_instr();
    for (int d = 0; d < N_DIR; d++) mem[dir_addr[d]] = dir_instr[d];

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_pc", Pc, 12'h000);
    chk("reset_inst_mem_read", InstMemRead, 1'b0);
    chk("reset_instruction_valid", InstructionValid, 1'b0);
    chk("reset_instruction", Instruction, 16'h0000);
    chk("reset_retired_count", RetiredCount, 16'h0000);
    chk("reset_fetch_error", FetchError, 1'b0);
    rst = 1'b0;

    pc_m = 12'h000; ret_m = 16'h0000; prev_stall = -1;
    dir_mode = 1'b1;
    for (int i = 0; i < N_DIR + N_RAND && !abort; i++) begin
      if (i == N_DIR) dir_mode = 1'b0;
      instr = mem[pc_m];
      if (i < N_DIR) begin
        {lpe, sj, sb, zf} = dir_ctl[i];
        stall = dir_stall[i];
      end else begin
        lpe = ($urandom_range(0, 9) < 7);
        sj = 1'($urandom); sb = 1'($urandom); zf = 1'($urandom);
        stall = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 5)) : 0;
      end
      sb_q.push_back('{pc: pc_m, instr: instr, retired: ret_m,
                       gap: (dir_mode && prev_stall >= 0) ? 4 + prev_stall : 0});
      ok = 1'b0;
      for (int c = 0; c < 400; c++) begin
        @(negedge clk);
        if (InstructionValid) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) begin
        n_cmp++; n_bad++;
        $display("FAIL valid_timeout: actual no InstructionValid in 400 cycles, required one for instruction %0d", i);
        abort = 1'b1;
      end else begin
        LoadPcEnable = lpe; SelectJumpPc = sj; SelectBranchPc = sb; ZeroFlag = zf;
        Stall = (stall > 0);
        @(negedge clk);
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          chk("stall_pc_frozen", Pc, pc_m);
          chk("stall_no_read", InstMemRead, 1'b0);
          chk("stall_retired_frozen", RetiredCount, ret_m);
        end
        Stall = 1'b0;
        pc_m = ref_next_pc(pc_m, instr, lpe, sj, sb, zf);
        ret_m = ret_m + 16'd1;
        prev_stall = stall;
      end
    end

    if (!abort) begin
      // Memory never answers: a timeout and retry must occur, then reset lands mid-wait.
      hold = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 50; c++) begin
        @(negedge clk);
        if (InstMemRead) begin
          ok = 1'b1;
          break;
        end
      end
      chk("hold_request_seen", ok, 1'b1);
      repeat (20) @(negedge clk);
      chk("hold_fetch_error", FetchError, 1'b1);
      chk("hold_read_reasserted", InstMemRead, 1'b1);
      chk("hold_same_address", InstMemAddress, pc_m);
      rst = 1'b1;
      @(negedge clk);
      chk("midwait_reset_pc", Pc, 12'h000);
      chk("midwait_reset_read", InstMemRead, 1'b0);
      chk("midwait_reset_fetch_error", FetchError, 1'b0);
      chk("midwait_reset_retired", RetiredCount, 16'h0000);
      chk("midwait_reset_valid", InstructionValid, 1'b0);
      hold = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      sb_q.push_back('{pc: 12'h000, instr: mem[0], retired: 16'h0000, gap: 0});
      ok = 1'b0;
      for (int c = 0; c < 400; c++) begin
        @(negedge clk);
        if (InstructionValid) begin
          ok = 1'b1;
          break;
        end
      end
      chk("post_reset_fetch", ok, 1'b1);
      repeat (3) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
